// File: rtl/aib_avmm_seq_pkg.sv
// Shared types for the AIB AVMM bring-up sequencer: FSM states, error codes, config table entry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package aib_avmm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_WAIT = 2'd1;  // waitreq held past the timeout on a request
    localparam logic [1:0] ERR_POLL = 2'd2;  // status never matched within the poll budget
    localparam logic [1:0] ERR_RDV  = 2'd3;  // read accepted but rdatavld never came back

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_entry_t;

    // Link is up only when every bit of the mask reads back as 1.
    function automatic logic status_ok(input logic [31:0] rdata, input logic [31:0] mask);
        return (rdata & mask) == mask;
    endfunction

endpackage

// File: rtl/aib_cfg_rom.sv
// Per-bridge AIB channel/PHY configuration table, indexed by write number.
// Latency: combinational.
// Backpressure: none; the caller holds idx stable while a write is stalled.
module aib_cfg_rom
    import aib_avmm_seq_pkg::*;
#(
    parameter int NBR_CFG = 8,
    parameter int IDX_W   = $clog2(NBR_CFG + 1)
) (
    input  logic [IDX_W-1:0] idx,
    output cfg_entry_t       entry
);

    // Table lookup; indices past the explicit entries fall back to a linear scratch
    // region, indices at or past NBR_CFG return zero.
    always_comb begin
        entry.addr = '0;
        entry.data = '0;
        if (int'(idx) < NBR_CFG) begin
            case (int'(idx))
                0: begin entry.addr = 32'h0000_0300; entry.data = 32'h0000_0001; end  // channel enable
                1: begin entry.addr = 32'h0000_0304; entry.data = 32'h0000_00A5; end  // tx/rx lane map
                2: begin entry.addr = 32'h0000_0308; entry.data = 32'h0000_1F10; end  // dll / dcc settings
                3: begin entry.addr = 32'h0000_030C; entry.data = 32'h0003_0002; end  // fifo mode and depth
                4: begin entry.addr = 32'h0000_0310; entry.data = 32'h8000_0040; end  // phy adapter control
                5: begin entry.addr = 32'h0000_0314; entry.data = 32'h0000_0007; end  // redundancy off
                6: begin entry.addr = 32'h0000_0318; entry.data = 32'h0055_AA00; end  // marker pattern
                7: begin entry.addr = 32'h0000_0320; entry.data = 32'h0000_0001; end  // calibration kick
                default: begin
                    entry.addr = 32'h0000_0400 + (32'(idx) << 2);
                    entry.data = 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: rtl/aib_avmm_link_seq.sv
// Bring-up sequencer: writes the AIB config table over AVMM, then polls link status until masked match.
// Latency: first request registered one cycle after start; link_up one cycle after the matching rdatavld.
// Backpressure: requests held stable while waitreq=1, bounded by WAIT_TMO, then error.
module aib_avmm_link_seq
    import aib_avmm_seq_pkg::*;
#(
    parameter int          NBR_CFG     = 8,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0200,
    parameter logic [31:0] STATUS_MASK = 32'h0000_0003,
    parameter int          POLL_GAP    = 16,
    parameter int          MAX_POLLS   = 256,
    parameter int          WAIT_TMO    = 1024
) (
    input  logic        avmm_clk,
    input  logic        avmm_rst,
    input  logic        start,
    output logic [31:0] o_cfg_avmm_addr,
    output logic [3:0]  o_cfg_avmm_byte_en,
    output logic        o_cfg_avmm_write,
    output logic        o_cfg_avmm_read,
    output logic [31:0] o_cfg_avmm_wdata,
    input  logic        i_cfg_avmm_waitreq,
    input  logic        i_cfg_avmm_rdatavld,
    input  logic [31:0] i_cfg_avmm_rdata,
    output logic        busy,
    output logic        link_up,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int IDX_W  = $clog2(NBR_CFG + 1);
    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    localparam int GAP_W  = $clog2(POLL_GAP + 1);
    localparam int TMO_W  = $clog2(WAIT_TMO + 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [31:0] addr_d, wdata_d;
    logic [3:0]  byte_en_d;
    logic        write_d, read_d, busy_d, link_up_d, error_d;

    cfg_entry_t rom_entry;

    // The ROM looks up the next index so the registered write data lines up with the request.
    aib_cfg_rom #(
        .NBR_CFG (NBR_CFG),
        .IDX_W   (IDX_W)
    ) u_cfg_rom (
        .idx   (idx_d),
        .entry (rom_entry)
    );

    // State, counter and output registers; reset drops every request at the next edge.
    always_ff @(posedge avmm_clk) begin
        if (avmm_rst) begin
            state_q            <= ST_IDLE;
            idx_q              <= '0;
            poll_q             <= '0;
            gap_q              <= '0;
            tmo_q              <= '0;
            err_code_q         <= ERR_NONE;
            o_cfg_avmm_addr    <= '0;
            o_cfg_avmm_wdata   <= '0;
            o_cfg_avmm_byte_en <= '0;
            o_cfg_avmm_write   <= 1'b0;
            o_cfg_avmm_read    <= 1'b0;
            busy               <= 1'b0;
            link_up            <= 1'b0;
            error              <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            poll_q             <= poll_d;
            gap_q              <= gap_d;
            tmo_q              <= tmo_d;
            err_code_q         <= err_code_d;
            o_cfg_avmm_addr    <= addr_d;
            o_cfg_avmm_wdata   <= wdata_d;
            o_cfg_avmm_byte_en <= byte_en_d;
            o_cfg_avmm_write   <= write_d;
            o_cfg_avmm_read    <= read_d;
            busy               <= busy_d;
            link_up            <= link_up_d;
            error              <= error_d;
        end
    end

    // Next-state and counter update. tmo_q counts stalled request cycles, and in RD_DATA
    // it is reused to bound the wait for rdatavld. Terminal compares precede increments.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_d     = poll_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        err_code_d = err_code_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_WRITE;
                    idx_d      = '0;
                    poll_d     = '0;
                    gap_d      = '0;
                    tmo_d      = '0;
                    err_code_d = ERR_NONE;
                end
            end
            ST_WRITE: begin
                if (!i_cfg_avmm_waitreq) begin
                    tmo_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NBR_CFG - 1)) begin
                        state_d = ST_RD_REQ;
                    end
                end else if (tmo_q == TMO_W'(WAIT_TMO - 1)) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_WAIT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RD_REQ: begin
                if (!i_cfg_avmm_waitreq) begin
                    tmo_d   = '0;
                    state_d = ST_RD_DATA;
                end else if (tmo_q == TMO_W'(WAIT_TMO - 1)) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_WAIT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RD_DATA: begin
                if (i_cfg_avmm_rdatavld) begin
                    poll_d = poll_q + POLL_W'(1);
                    tmo_d  = '0;
                    if (status_ok(i_cfg_avmm_rdata, STATUS_MASK)) begin
                        state_d = ST_DONE;
                    end else if (poll_q == POLL_W'(MAX_POLLS - 1)) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_POLL;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end else if (tmo_q == TMO_W'(WAIT_TMO - 1)) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_RDV;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = ST_RD_REQ;
                    tmo_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered AVMM signals match the state register.
    always_comb begin
        write_d   = (state_d == ST_WRITE);
        read_d    = (state_d == ST_RD_REQ);
        addr_d    = '0;
        wdata_d   = '0;
        if (write_d) begin
            addr_d  = rom_entry.addr;
            wdata_d = rom_entry.data;
        end else if (read_d) begin
            addr_d = STATUS_ADDR;
        end
        byte_en_d = (write_d || read_d) ? 4'hF : 4'h0;
        busy_d    = (state_d == ST_WRITE) || (state_d == ST_RD_REQ) ||
                    (state_d == ST_RD_DATA) || (state_d == ST_GAP);
        link_up_d = (state_d == ST_DONE);
        error_d   = (state_d == ST_ERR);
    end

    assign err_code = err_code_q;

endmodule

// File: tb/tb_aib_avmm_link_seq.sv
// Bench for aib_avmm_link_seq: behavioural AVMM slave, directed bring-up scenarios, random runs.
// Latency: n/a.
// Backpressure: slave drives waitreq per scenario (none, single stall, stuck, random).
module tb_aib_avmm_link_seq;

    localparam int MAX_POLLS = 4;
    localparam int WAIT_TMO  = 1024;
    localparam int POLL_GAP  = 16;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0200;
    localparam logic [31:0] TBL_A [8] = '{32'h300, 32'h304, 32'h308, 32'h30C,
                                          32'h310, 32'h314, 32'h318, 32'h320};
    localparam logic [31:0] TBL_D [8] = '{32'h0000_0001, 32'h0000_00A5, 32'h0000_1F10, 32'h0003_0002,
                                          32'h8000_0040, 32'h0000_0007, 32'h0055_AA00, 32'h0000_0001};

    logic        avmm_clk = 1'b0;
    logic        avmm_rst;
    logic        start;
    logic [31:0] avmm_addr, avmm_wdata, avmm_rdata;
    logic [3:0]  avmm_be;
    logic        avmm_write, avmm_read, avmm_waitreq, avmm_rdatavld;
    logic        busy, link_up, error;
    logic [1:0]  err_code;

    always #5 avmm_clk = ~avmm_clk;

    aib_avmm_link_seq #(
        .NBR_CFG     (8),
        .STATUS_ADDR (STAT_ADDR),
        .STATUS_MASK (32'h0000_0003),
        .POLL_GAP    (POLL_GAP),
        .MAX_POLLS   (MAX_POLLS),
        .WAIT_TMO    (WAIT_TMO)
    ) dut (
        .avmm_clk            (avmm_clk),
        .avmm_rst            (avmm_rst),
        .start               (start),
        .o_cfg_avmm_addr     (avmm_addr),
        .o_cfg_avmm_byte_en  (avmm_be),
        .o_cfg_avmm_write    (avmm_write),
        .o_cfg_avmm_read     (avmm_read),
        .o_cfg_avmm_wdata    (avmm_wdata),
        .i_cfg_avmm_waitreq  (avmm_waitreq),
        .i_cfg_avmm_rdatavld (avmm_rdatavld),
        .i_cfg_avmm_rdata    (avmm_rdata),
        .busy                (busy),
        .link_up             (link_up),
        .error               (error),
        .err_code            (err_code)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Slave configuration: 0 always ready, 1 stall one write, 2 stuck waitreq, 3 random waitreq
    int          mode = 0;
    int          stall_idx = 0;
    int          stall_left = 0;
    int          lat_max = 1;
    bit          rdv_never = 1'b0;
    bit          spur_en = 1'b0;
    logic [31:0] st_q[$];
    logic [31:0] st_def = 32'h3;

    // Slave logs and protocol monitors
    logic [31:0] log_a[$], log_d[$];
    int          rd_first[$], rd_acc[$];
    int          cyc = 0, wr_hi = 0, rdv_cnt = 0;
    int          rw_viol = 0, be_viol = 0, stab_viol = 0, ra_viol = 0;
    bit          prev_stall = 1'b0, prev_read = 1'b0;
    logic [31:0] prev_a = '0, prev_d = '0;

    // Behavioural AVMM slave: decides waitreq/rdatavld at each negedge for the next posedge.
    initial begin
        avmm_waitreq  = 1'b0;
        avmm_rdatavld = 1'b0;
        avmm_rdata    = '0;
        forever begin
            @(negedge avmm_clk);
            cyc++;
            if (avmm_write && avmm_read) rw_viol++;
            if (avmm_be !== ((avmm_write || avmm_read) ? 4'hF : 4'h0)) be_viol++;
            if (avmm_write && prev_stall && (avmm_addr !== prev_a || avmm_wdata !== prev_d)) stab_viol++;
            if (avmm_read && avmm_addr !== STAT_ADDR) ra_viol++;
            if (avmm_write) wr_hi++;
            if (avmm_read && !prev_read) rd_first.push_back(cyc);
            prev_read     = avmm_read;
            avmm_rdatavld = 1'b0;
            avmm_waitreq  = 1'b0;
            if (avmm_rst) begin
                rdv_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (rdv_cnt > 0) begin
                    rdv_cnt--;
                    if (rdv_cnt == 0 && !rdv_never) begin
                        avmm_rdatavld = 1'b1;
                        if (st_q.size() > 0) avmm_rdata = st_q.pop_front();
                        else avmm_rdata = st_def;
                    end
                end
                if (avmm_write || avmm_read) begin
                    case (mode)
                        1: if (avmm_write && log_a.size() == stall_idx && stall_left > 0) begin
                               avmm_waitreq = 1'b1;
                               stall_left--;
                           end
                        2: avmm_waitreq = 1'b1;
                        3: avmm_waitreq = ($urandom_range(0, 2) == 0);
                        default: avmm_waitreq = 1'b0;
                    endcase
                end
                prev_stall = avmm_write && avmm_waitreq;
                prev_a     = avmm_addr;
                prev_d     = avmm_wdata;
                if (avmm_write && !avmm_waitreq) begin
                    log_a.push_back(avmm_addr);
                    log_d.push_back(avmm_wdata);
                end
                if (avmm_read && !avmm_waitreq) begin
                    rd_acc.push_back(cyc);
                    rdv_cnt = $urandom_range(1, lat_max);
                end
                if (spur_en && avmm_write && !avmm_rdatavld && $urandom_range(0, 3) == 0) begin
                    avmm_rdatavld = 1'b1;
                    avmm_rdata    = 32'hFFFF_FFFF;
                end
            end
        end
    end

    // Reference: the run ends at the first status read whose low two bits are both set, or after MAX_POLLS reads.
    function automatic int exp_reads(input logic [31:0] seq[$], input logic [31:0] def, output bit up);
        logic [31:0] s;
        up = 1'b0;
        for (int p = 0; p < MAX_POLLS; p++) begin
            s = (p < seq.size()) ? seq[p] : def;
            if ((s & 32'h3) == 32'h3) begin
                up = 1'b1;
                return p + 1;
            end
        end
        return MAX_POLLS;
    endfunction

    // Pulse start, optionally pulse it again at cycle restart_at, and wait for link_up or error.
    task automatic run_seq(input int budget, input int restart_at, output int cycles, output int first_wr);
        log_a.delete(); log_d.delete(); rd_first.delete(); rd_acc.delete();
        wr_hi    = 0;
        cycles   = -1;
        first_wr = -1;
        start    = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge avmm_clk); #1;
            start = (i == restart_at);
            if (avmm_write && first_wr < 0) first_wr = i;
            if (link_up || error) begin
                cycles = i;
                break;
            end
        end
        start = 1'b0;
        if (cycles < 0) chk("run_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_run(input string tag, input int exp_wr, input int exp_rd,
                             input logic exp_up, input logic [1:0] exp_code);
        int bad;
        bad = 0;
        for (int k = 0; k < log_a.size(); k++)
            if (k >= 8 || log_a[k] !== TBL_A[k] || log_d[k] !== TBL_D[k]) bad++;
        chk({tag, "_wr_cnt"}, 64'(log_a.size()), 64'(exp_wr));
        chk({tag, "_wr_order"}, 64'(bad), 64'd0);
        chk({tag, "_rd_cnt"}, 64'(rd_acc.size()), 64'(exp_rd));
        chk({tag, "_link_up"}, 64'(link_up), 64'(exp_up));
        chk({tag, "_error"}, 64'(error), 64'(!exp_up));
        chk({tag, "_err_code"}, 64'(err_code), 64'(exp_code));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Run for n_cyc cycles after start, confirm the expected phase, reset, and check everything drops.
    task automatic reset_mid(input string tag, input int n_cyc, input logic [2:0] exp_phase);
        start = 1'b1;
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge avmm_clk); #1;
            start = 1'b0;
        end
        chk({tag, "_phase"}, 64'({busy, avmm_read, avmm_write}), 64'(exp_phase));
        avmm_rst = 1'b1;
        @(negedge avmm_clk); #1;
        chk({tag, "_req"}, 64'({avmm_write, avmm_read, avmm_be}), 64'd0);
        chk({tag, "_addr_wdata"}, {avmm_addr, avmm_wdata}, 64'd0);
        chk({tag, "_status"}, 64'({busy, link_up, error, err_code}), 64'd0);
        avmm_rst = 1'b0;
        mode     = 0;
    endtask

    int cycles, first_wr, min_gap, nrd;
    bit up;

    initial begin
        avmm_rst = 1'b1;
        start    = 1'b0;
        repeat (3) @(negedge avmm_clk);
        #1;
        chk("rst_req", 64'({avmm_write, avmm_read, avmm_be}), 64'd0);
        chk("rst_addr_wdata", {avmm_addr, avmm_wdata}, 64'd0);
        chk("rst_status", 64'({busy, link_up, error, err_code}), 64'd0);
        avmm_rst = 1'b0;
        @(negedge avmm_clk); #1;

        // Zero-wait slave, status matches on the first read
        mode = 0; lat_max = 1; st_q.delete(); st_q.push_back(32'h3); st_def = 32'h3;
        run_seq(200, 0, cycles, first_wr);
        chk("t1_first_wr_cyc", 64'(first_wr), 64'd1);
        chk("t1_link_cyc", 64'(cycles), 64'd11);
        chk("t1_wr_hi", 64'(wr_hi), 64'd8);
        check_run("t1", 8, 1, 1'b1, 2'd0);

        // Five-cycle stall on write #3, plus a start pulse while busy
        mode = 1; stall_idx = 2; stall_left = 5; st_q.delete();
        run_seq(200, 4, cycles, first_wr);
        chk("t2_wr_hi", 64'(wr_hi), 64'd13);
        check_run("t2", 8, 1, 1'b1, 2'd0);

        // Status 1,1,1 then 3 with poll gaps
        mode = 0; lat_max = 3; st_q.delete();
        st_q.push_back(32'h1); st_q.push_back(32'h1); st_q.push_back(32'h1); st_q.push_back(32'h3);
        run_seq(500, 0, cycles, first_wr);
        check_run("t3", 8, 4, 1'b1, 2'd0);
        min_gap = 1000000;
        for (int k = 0; k + 1 < rd_first.size() && k < rd_acc.size(); k++)
            if (rd_first[k+1] - rd_acc[k] - 1 < min_gap) min_gap = rd_first[k+1] - rd_acc[k] - 1;
        chk("t3_gap_min", 64'(min_gap >= POLL_GAP), 64'd1);

        // Status stuck at 1: poll budget exhausted
        st_q.delete(); st_def = 32'h1;
        run_seq(500, 0, cycles, first_wr);
        check_run("t4", 8, MAX_POLLS, 1'b0, 2'd2);

        // Stuck waitreq, then a healthy restart
        mode = 2; st_def = 32'h3;
        run_seq(3000, 0, cycles, first_wr);
        chk("t5_wr_hi", 64'(wr_hi), 64'(WAIT_TMO));
        check_run("t5", 0, 0, 1'b0, 2'd1);
        mode = 0; lat_max = 1;
        run_seq(200, 0, cycles, first_wr);
        check_run("t5b", 8, 1, 1'b1, 2'd0);

        // Read accepted but rdatavld never returns
        rdv_never = 1'b1;
        run_seq(3000, 0, cycles, first_wr);
        check_run("t6", 8, 1, 1'b0, 2'd3);
        rdv_never = 1'b0;

        // Reset in GAP, then in WRITE while the slave is stalling
        mode = 0; lat_max = 1; st_q.delete(); st_def = 32'h1;
        reset_mid("t7_gap", 14, 3'b100);
        mode = 1; stall_idx = 2; stall_left = 10;
        log_a.delete(); log_d.delete();
        reset_mid("t7_write", 5, 3'b101);
        st_def = 32'h3; st_q.delete();
        run_seq(200, 0, cycles, first_wr);
        check_run("t8", 8, 1, 1'b1, 2'd0);

        // Randomized waitreq, read latency, status sequences and stray rdatavld
        spur_en = 1'b1;
        for (int it = 0; it < 16; it++) begin
            mode    = ($urandom_range(0, 1) == 1) ? 3 : 0;
            lat_max = $urandom_range(1, 4);
            st_q.delete();
            for (int j = 0; j < $urandom_range(0, 5); j++) st_q.push_back(32'($urandom_range(0, 3)));
            st_def = 32'($urandom_range(0, 3));
            nrd = exp_reads(st_q, st_def, up);
            run_seq(2000, 0, cycles, first_wr);
            check_run($sformatf("rnd%0d", it), 8, nrd, up, up ? 2'd0 : 2'd2);
        end
        spur_en = 1'b0;

        chk("rw_overlap", 64'(rw_viol), 64'd0);
        chk("byte_en", 64'(be_viol), 64'd0);
        chk("stall_stable", 64'(stab_viol), 64'd0);
        chk("rd_addr", 64'(ra_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
